// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encodings and line defaults for uart_tx/uart_rx
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 9600;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    BREAK  = ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer for asynchronous input pins
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 with mid-bit sampling and framing check
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       parity_err
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev_q;
  logic                 fall;
  uart_state_e          state_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_mis_q;
  logic                 parity_err_q;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  assign fall = rx_prev_q & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_prev_q   <= 1'b1;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_prev_q   <= rx_s;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (fall) state_q <= START;
        end
        START: begin
          // A line that is high again at the start-bit centre was only a glitch
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == DIV_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt_q == DIV_LAST) begin
            clk_cnt_q <= '0;
            par_mis_q <= rx_s ^ (^shift_q);
            state_q   <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (clk_cnt_q == DIV_LAST) begin
            clk_cnt_q <= '0;
            if (rx_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_mis_q;
`endif
              state_q    <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        BREAK: begin
          // Held-low line must return high before another start edge counts
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with a behavioural serial line driver
module tb_uart_rx;

  localparam int CLK_FREQ = 120_000;
  localparam int BAUD     = 10_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT = 2 + HALF + 9 * DIV + 1 + (PAR ? DIV : 0);

  typedef struct {
    bit         is_err;
    bit         perr;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic       parity_err;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q[$];
  logic [7:0] model_last = 8'h00;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference: a good stop delivers the byte (parity flagged if flipped),
  // a low stop reports a framing error carrying the previous good byte.
  task automatic send(input logic [7:0] d, input bit stop, input bit pflip);
    exp_t e;
    e.t0     = cyc;
    e.is_err = !stop;
    e.perr   = stop && PAR && pflip;
    e.data   = stop ? d : model_last;
    if (stop) model_last = d;
    exp_q.push_back(e);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ pflip);
`endif
    bit_time(stop);
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        int   lat;
        @(negedge clk);
        if (rx_valid || frame_err || parity_err) begin
          check("exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: valid=%0b ferr=%0b perr=%0b data=%0h", rx_valid, frame_err, parity_err, rx_data);
          end else begin
            e = exp_q.pop_front();
            check("frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
            check("rx_valid", {31'd0, rx_valid}, {31'd0, !e.is_err});
            check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
            check("busy_at_strobe", {31'd0, busy}, {31'd0, e.is_err});
            lat = cyc - e.t0;
            checks++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
              errors++;
              $display("FAIL latency: got %0d, expected %0d +/-1", lat, LAT);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2 * DIV);

    send(8'hA5, 1'b1, 1'b0);
    idle(2 * DIV);

    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    idle(2 * DIV);

    // Short low glitch: enters START, then falls back to IDLE silently
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (HALF + 2) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    idle(DIV);

    send(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    idle(DIV);
    check("break_cleared", {31'd0, busy}, 32'd0);
    send(8'h81, 1'b1, 1'b0);
    idle(2 * DIV);

    // Reset in the middle of bit 4 of 8'hC3
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) bit_time(1'(8'hC3 >> i));
    rx = 1'b0;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    model_last = 8'h00;
    repeat (3) @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * DIV);
    check("post_reset_idle", {31'd0, busy}, 32'd0);
    send(8'h5A, 1'b1, 1'b0);
    idle(2 * DIV);

    for (int i = 0; i < 256; i++) send(8'(i), 1'b1, (i == 77));
    idle(2 * DIV);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      bit         good;
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      send(d, good, ($urandom_range(0, 5) == 0));
      if (!good) begin
        rx = 1'b0;
        repeat ($urandom_range(DIV, 3 * DIV)) @(negedge clk);
        idle(DIV);
      end
      idle($urandom_range(0, 2 * DIV));
    end

    for (int k = 0; k < 4 * DIV && exp_q.size() != 0; k++) @(negedge clk);
    idle(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
